store_buffer: RTL

- In-order FIFO between the superscalar pipeline's store path and the data Memory's single write port (NUM_WRITE_PORTS=1).
- Accepts committed stores, drains one per cycle into the memory write port when enabled, and forwards buffered data to loads whose word address matches.
- Also drives the memory read port for loads.
- Word-addressed; no byte masks.

---
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer.sv | 101 ++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer bundle: pipeline store/load requests plus the single memory port pair.
// The slave modport is the buffer; the master modport is the pipeline/memory side.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  drain_en;
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_fwd_hit;
  logic                  empty;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read_enable;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  st_valid, st_addr, st_data, drain_en, ld_valid, ld_addr, mem_read_data,
    output st_ready, ld_data, ld_fwd_hit, empty,
    output mem_write_enable, mem_write_addr, mem_write_data,
    output mem_read_enable, mem_read_addr
  );

  modport master (
    output st_valid, st_addr, st_data, drain_en, ld_valid, ld_addr, mem_read_data,
    input  st_ready, ld_data, ld_fwd_hit, empty,
    input  mem_write_enable, mem_write_addr, mem_write_data,
    input  mem_read_enable, mem_read_addr
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: accepts committed stores, drains one per cycle to the memory
// write port, and forwards the youngest matching buffered store to combinational loads.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);

  localparam int          PTR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Index of the entry 'off' positions younger than p, wrapping at DEPTH (not a power of 2).
  function automatic logic [PTR_W-1:0] ptr_offset(input logic [PTR_W-1:0] p,
                                                  input int unsigned   off);
    int unsigned sum;
    sum = 32'(p) + off;
    if (sum >= DEPTH_U) sum = sum - DEPTH_U;
    return sum[PTR_W-1:0];
  endfunction

  assign sb.st_ready         = (count != FULL_CNT);
  assign sb.empty            = (count == '0);
  assign sb.mem_write_enable = sb.drain_en && (count != '0);
  assign sb.mem_write_addr   = entry_addr[head];
  assign sb.mem_write_data   = entry_data[head];
  assign sb.mem_read_enable  = sb.ld_valid;
  assign sb.mem_read_addr    = sb.ld_addr;

  assign push = sb.st_valid && sb.st_ready;
  assign pop  = sb.mem_write_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; liveness is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= sb.st_addr;
      entry_data[tail] <= sb.st_data;
    end
  end

  // Walk live entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = ptr_offset(head, i);
      if ((CNT_W'(i) < count) && (entry_addr[idx] == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[idx];
      end
    end
  end

  always_comb begin
    sb.ld_fwd_hit = 1'b0;
    sb.ld_data    = '0;
    if (sb.ld_valid) begin
      sb.ld_fwd_hit = fwd_hit;
      sb.ld_data    = fwd_hit ? fwd_data : sb.mem_read_data;
    end
  end

endmodule
